multiport_reg_file: RTL

Parametrised successor to the 64x32 two-read register file. Configurable width, depth and read-port count, with a write-to-read bypass option and an optional hardwired-zero register. After reset, a hardware clear sequencer zeroes every entry and holds `busy` high while it runs. It sits in the decode stage of the pipelined CPU, feeding operand registers, and takes writeback from the WB stage.

---
 rtl/cpu_rf_pkg.sv | 11 +
 rtl/rf_clear_fsm.sv | 53 +++++
 rtl/multiport_reg_file.sv | 59 +++++
 3 files changed

// File: rtl/cpu_rf_pkg.sv
// Shared register-file definitions: clear-sequencer states and default geometry
// used by the register file and by the instruction/data memory wrappers.
package cpu_rf_pkg;
  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 64;

  typedef enum logic {
    RF_CLEAR,
    RF_RUN
  } rf_state_e;
endpackage

// File: rtl/rf_clear_fsm.sv
// Post-reset clear sequencer: walks every entry once, writing zero, and holds
// busy until the last entry has been written.
module rf_clear_fsm
  import cpu_rf_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy
);
  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] clr_idx, idx_nxt;
  logic              busy_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RF_CLEAR;
      clr_idx <= '0;
      busy    <= 1'b1;
    end else begin
      state   <= state_nxt;
      clr_idx <= idx_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = clr_idx;
    busy_nxt  = busy;
    clr_we    = 1'b0;
    case (state)
      RF_CLEAR: begin
        // a reset edge must leave the array untouched
        clr_we = rst_n;
        if (clr_idx == ADDR_W'(DEPTH - 1)) begin
          state_nxt = RF_RUN;
          busy_nxt  = 1'b0;
        end else begin
          idx_nxt = clr_idx + 1'b1;
        end
      end
      RF_RUN:  state_nxt = RF_RUN;
      default: state_nxt = RF_CLEAR;
    endcase
  end

  assign clr_addr = clr_idx;
endmodule

// File: rtl/multiport_reg_file.sv
// Parametrised multi-read-port register file with optional write bypass,
// optional hardwired zero entry and a hardware clear after reset.
module multiport_reg_file
  import cpu_rf_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wrt,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic                     busy
);
  logic [WIDTH-1:0]        rf [DEPTH];
  logic                    clr_we;
  logic [ADDR_W-1:0]       clr_addr;
  logic                    wr_en;
  logic [NUM_RD*WIDTH-1:0] rd_nxt;

  rf_clear_fsm #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  assign wr_en = wrt && !busy && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clr_we)     rf[clr_addr] <= '0;
      else if (wr_en) rf[wr_addr]  <= wr_data;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[g*ADDR_W +: ADDR_W];
    // zero entry wins over bypass so r0 never leaks a discarded write
    assign rd_nxt[g*WIDTH +: WIDTH] =
      ((ZERO_REG != 0) && (a == '0))               ? '0      :
      ((BYPASS != 0) && wr_en && (wr_addr == a))    ? wr_data :
                                                      rf[a];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || busy) rd_data <= '0;
    else                rd_data <= rd_nxt;
  end
endmodule
